yannickreiss_dot_div: RTL and testbench

YANNICKREISS_DOT_DIV -- requirements
Module: yannickreiss_dot_div

---
 rtl/yannickreiss_dot_div.sv | 268 ++++++++++++++++++++++++++
 tb/tb_yannickreiss_dot_div.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/yannickreiss_dot_div.sv
// yannickreiss_dot_div
// Sequential 6-bit by 3-bit unsigned divider with a 3-bit beat interface.
// Operands arrive as three beats: dividend high, dividend low, divisor.
// Results leave as three beats: quotient high, quotient low, remainder.
// The core is a restoring divider producing one quotient bit per cycle.
// A zero divisor skips the calculation and flags err on the result.
// The bus is declared [0:7], so bit 0 of io_in and io_out is the MSB.

module yannickreiss_dot_div (
    input  logic [0:7] io_in,
    output logic [0:7] io_out
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_LO  = 3'd1,
        ST_LOAD_DIV = 3'd2,
        ST_CALC     = 3'd3,
        ST_OUT      = 3'd4
    } state_t;

    // Index of the last division step; the core runs six steps for six quotient bits.
    localparam logic [2:0] LAST_STEP = 3'd5;

    // One restoring-division step.
    // Shift the next dividend bit into the partial remainder.
    // Subtract the divisor only when the result stays non-negative.
    // Return {quotient_bit, new_partial_remainder}.
    // The caller keeps rem below the divisor (at most 7), so the shifted
    // trial never exceeds 15. The difference therefore fits in 4 bits.
    function automatic logic [4:0] div_step(
        input logic [3:0] rem,
        input logic       dvd_bit,
        input logic [2:0] divisor
    );
        logic [4:0] trial;
        logic [3:0] diff;
        logic       ge;
        trial = {rem, dvd_bit};
        ge    = (trial >= {2'b00, divisor});
        diff  = trial[3:0] - {1'b0, divisor};
        if (ge) begin
            div_step = {1'b1, diff};
        end else begin
            div_step = {1'b0, trial[3:0]};
        end
    endfunction

    // Input field breakout
    logic       clk_s;
    logic       rst_s;
    logic       in_valid_s;
    logic       abort_s;
    logic       ack_s;
    logic [2:0] data_s;

    assign clk_s      = io_in[0];
    assign rst_s      = io_in[1];
    assign in_valid_s = io_in[2];
    assign abort_s    = io_in[3];
    assign ack_s      = io_in[4];
    assign data_s     = io_in[5:7];

    // Architectural state
    state_t     state_r;
    logic [5:0] dvd_r;        // dividend; shifted left during CALC
    logic [2:0] div_r;        // divisor
    logic [5:0] q_r;          // quotient; bits shift in from the LSB
    logic [3:0] rem_r;        // partial remainder
    logic [2:0] cnt_r;        // step counter inside CALC
    logic       busy_r;
    logic       out_valid_r;
    logic       err_r;
    logic [1:0] idx_r;
    logic [2:0] odata_r;

    // Next-state values
    state_t     state_next_s;
    logic [5:0] dvd_next_s;
    logic [2:0] div_next_s;
    logic [5:0] q_next_s;
    logic [3:0] rem_next_s;
    logic [2:0] cnt_next_s;
    logic       busy_next_s;
    logic       out_valid_next_s;
    logic       err_next_s;
    logic [1:0] idx_next_s;
    logic [2:0] odata_next_s;

    // Division step datapath, valid while in CALC
    logic [4:0] step_s;
    logic [5:0] q_shift_s;

    assign step_s    = div_step(rem_r, dvd_r[5], div_r);
    assign q_shift_s = {q_r[4:0], step_s[4]};

    // Next-state and next-output logic; abort overrides every state
    always_comb begin
        state_next_s     = state_r;
        dvd_next_s       = dvd_r;
        div_next_s       = div_r;
        q_next_s         = q_r;
        rem_next_s       = rem_r;
        cnt_next_s       = cnt_r;
        busy_next_s      = busy_r;
        out_valid_next_s = out_valid_r;
        err_next_s       = err_r;
        idx_next_s       = idx_r;
        odata_next_s     = odata_r;

        if (abort_s) begin
            state_next_s     = ST_IDLE;
            dvd_next_s       = 6'd0;
            div_next_s       = 3'd0;
            q_next_s         = 6'd0;
            rem_next_s       = 4'd0;
            cnt_next_s       = 3'd0;
            busy_next_s      = 1'b0;
            out_valid_next_s = 1'b0;
            err_next_s       = 1'b0;
            idx_next_s       = 2'd0;
            odata_next_s     = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid_s) begin
                        dvd_next_s   = {data_s, 3'b000};
                        state_next_s = ST_LOAD_LO;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end

                ST_LOAD_LO: begin
                    if (in_valid_s) begin
                        dvd_next_s   = {dvd_r[5:3], data_s};
                        state_next_s = ST_LOAD_DIV;
                    end else begin
                        state_next_s = ST_LOAD_LO;
                    end
                end

                ST_LOAD_DIV: begin
                    if (in_valid_s) begin
                        if (data_s != 3'd0) begin
                            div_next_s   = data_s;
                            q_next_s     = 6'd0;
                            rem_next_s   = 4'd0;
                            cnt_next_s   = 3'd0;
                            busy_next_s  = 1'b1;
                            state_next_s = ST_CALC;
                        end else begin
                            // Division by zero: report Q=0, R=0 with err set.
                            div_next_s       = 3'd0;
                            q_next_s         = 6'd0;
                            rem_next_s       = 4'd0;
                            cnt_next_s       = 3'd0;
                            busy_next_s      = 1'b0;
                            out_valid_next_s = 1'b1;
                            err_next_s       = 1'b1;
                            idx_next_s       = 2'd0;
                            odata_next_s     = 3'd0;
                            state_next_s     = ST_OUT;
                        end
                    end else begin
                        state_next_s = ST_LOAD_DIV;
                    end
                end

                ST_CALC: begin
                    dvd_next_s = {dvd_r[4:0], 1'b0};
                    q_next_s   = q_shift_s;
                    rem_next_s = step_s[3:0];
                    if (cnt_r == LAST_STEP) begin
                        // The final bit lands this edge, so beat 0 takes it from the shifted value.
                        cnt_next_s       = 3'd0;
                        busy_next_s      = 1'b0;
                        out_valid_next_s = 1'b1;
                        err_next_s       = 1'b0;
                        idx_next_s       = 2'd0;
                        odata_next_s     = q_shift_s[5:3];
                        state_next_s     = ST_OUT;
                    end else begin
                        cnt_next_s   = cnt_r + 3'd1;
                        busy_next_s  = 1'b1;
                        state_next_s = ST_CALC;
                    end
                end

                ST_OUT: begin
                    if (ack_s) begin
                        case (idx_r)
                            2'd0: begin
                                idx_next_s   = 2'd1;
                                odata_next_s = q_r[2:0];
                            end
                            2'd1: begin
                                idx_next_s   = 2'd2;
                                odata_next_s = rem_r[2:0];
                            end
                            default: begin
                                state_next_s     = ST_IDLE;
                                dvd_next_s       = 6'd0;
                                div_next_s       = 3'd0;
                                q_next_s         = 6'd0;
                                rem_next_s       = 4'd0;
                                cnt_next_s       = 3'd0;
                                busy_next_s      = 1'b0;
                                out_valid_next_s = 1'b0;
                                err_next_s       = 1'b0;
                                idx_next_s       = 2'd0;
                                odata_next_s     = 3'd0;
                            end
                        endcase
                    end else begin
                        state_next_s = ST_OUT;
                    end
                end

                default: begin
                    state_next_s     = ST_IDLE;
                    dvd_next_s       = 6'd0;
                    div_next_s       = 3'd0;
                    q_next_s         = 6'd0;
                    rem_next_s       = 4'd0;
                    cnt_next_s       = 3'd0;
                    busy_next_s      = 1'b0;
                    out_valid_next_s = 1'b0;
                    err_next_s       = 1'b0;
                    idx_next_s       = 2'd0;
                    odata_next_s     = 3'd0;
                end
            endcase
        end
    end

    // State, datapath and output registers; reset clears everything at once
    always_ff @(posedge clk_s or posedge rst_s) begin
        if (rst_s) begin
            state_r     <= ST_IDLE;
            dvd_r       <= 6'd0;
            div_r       <= 3'd0;
            q_r         <= 6'd0;
            rem_r       <= 4'd0;
            cnt_r       <= 3'd0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            idx_r       <= 2'd0;
            odata_r     <= 3'd0;
        end else begin
            state_r     <= state_next_s;
            dvd_r       <= dvd_next_s;
            div_r       <= div_next_s;
            q_r         <= q_next_s;
            rem_r       <= rem_next_s;
            cnt_r       <= cnt_next_s;
            busy_r      <= busy_next_s;
            out_valid_r <= out_valid_next_s;
            err_r       <= err_next_s;
            idx_r       <= idx_next_s;
            odata_r     <= odata_next_s;
        end
    end

    assign io_out = {busy_r, out_valid_r, err_r, idx_r, odata_r};

endmodule

// File: tb/tb_yannickreiss_dot_div.sv
// Self-checking bench for yannickreiss_dot_div.
// Expected beats come from a behavioural divide and are queued when operands are sent.

module tb_yannickreiss_dot_div;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic       abort    = 1'b0;
    logic       ack      = 1'b0;
    logic [2:0] data     = 3'd0;
    logic [0:7] io_in;
    logic [0:7] io_out;

    assign io_in = {clk, rst, in_valid, abort, ack, data};

    yannickreiss_dot_div dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb[$];
    int         waits;
    int         busies;
    logic [7:0] e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [2:0] d);
        in_valid = 1'b1;
        data     = d;
        tick();
        in_valid = 1'b0;
        data     = 3'($urandom_range(7, 0));
    endtask

    // Expected io_out per beat: busy=0, out_valid=1, err, index, data.
    task automatic push_txn(input logic [2:0] hi, input logic [2:0] lo, input logic [2:0] dv);
        logic [5:0] dd;
        logic [5:0] q;
        logic [2:0] r;
        dd = {hi, lo};
        if (dv == 3'd0) begin
            sb.push_back({2'b01, 1'b1, 2'd0, 3'd0});
            sb.push_back({2'b01, 1'b1, 2'd1, 3'd0});
            sb.push_back({2'b01, 1'b1, 2'd2, 3'd0});
        end else begin
            q = dd / {3'd0, dv};
            r = 3'(dd % {3'd0, dv});
            sb.push_back({2'b01, 1'b0, 2'd0, q[5:3]});
            sb.push_back({2'b01, 1'b0, 2'd1, q[2:0]});
            sb.push_back({2'b01, 1'b0, 2'd2, r});
        end
    endtask

    task automatic send_txn(input logic [2:0] hi, input logic [2:0] lo, input logic [2:0] dv,
                            input int gap, input logic expect_result);
        if (expect_result) begin
            push_txn(hi, lo, dv);
        end
        send_beat(hi);
        repeat (gap) tick();
        send_beat(lo);
        repeat (gap) tick();
        send_beat(dv);
    endtask

    // Count cycles until out_valid, and how many of them showed busy; bounded.
    task automatic wait_out(output int w, output int b);
        w = 0;
        b = 0;
        while (io_out[1] !== 1'b1 && w < 20) begin
            if (io_out[0] === 1'b1) b++;
            tick();
            w++;
        end
        chk("out_valid_seen", {7'd0, io_out[1]}, 8'd1);
    endtask

    task automatic drain(input string tag, input int gap, input logic noise);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ex;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s: scoreboard empty, observed %h expected a queued beat", tag, io_out);
            end else begin
                ex = sb.pop_front();
                chk(tag, io_out, ex);
                if (gap > 0) begin
                    repeat (gap) tick();
                    chk({tag, "_hold"}, io_out, ex);
                end
            end
            ack      = 1'b1;
            in_valid = noise;
            data     = 3'($urandom_range(7, 0));
            tick();
            ack      = 1'b0;
            in_valid = 1'b0;
        end
        chk({tag, "_idle"}, io_out, 8'h00);
    endtask

    initial begin
        // Reset with in_valid asserted: must be ignored
        in_valid = 1'b1;
        data     = 3'd5;
        tick();
        tick();
        chk("reset_state", io_out, 8'h00);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        chk("post_reset_idle", io_out, 8'h00);

        // 45 / 6 -> Q=7 R=3, six busy cycles
        send_txn(3'b101, 3'b101, 3'b110, 0, 1'b1);
        wait_out(waits, busies);
        chk("t45_wait", 8'(waits), 8'd6);
        chk("t45_busy", 8'(busies), 8'd6);
        drain("t45", 0, 1'b0);

        // 63 / 1 with load gaps and hold checks between acks
        send_txn(3'b111, 3'b111, 3'b001, 2, 1'b1);
        wait_out(waits, busies);
        chk("t63_wait", 8'(waits), 8'd6);
        drain("t63", 1, 1'b0);

        // 5 / 7 with ack held during CALC and in_valid noise during OUT
        send_txn(3'b000, 3'b101, 3'b111, 0, 1'b1);
        ack = 1'b1;
        wait_out(waits, busies);
        ack = 1'b0;
        chk("t5_wait", 8'(waits), 8'd6);
        chk("t5_busy", 8'(busies), 8'd6);
        drain("t5", 0, 1'b1);

        // 20 / 0 -> err, immediate out_valid, no busy
        send_txn(3'b010, 3'b100, 3'b000, 0, 1'b1);
        wait_out(waits, busies);
        chk("t20_wait", 8'(waits), 8'd0);
        chk("t20_busy", 8'(busies), 8'd0);
        drain("t20", 0, 1'b0);

        // Abort on third CALC cycle, together with in_valid and ack
        send_txn(3'b011, 3'b110, 3'b101, 0, 1'b0);
        tick();
        tick();
        chk("abort_pre_busy", {7'd0, io_out[0]}, 8'd1);
        abort    = 1'b1;
        in_valid = 1'b1;
        ack      = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        ack      = 1'b0;
        chk("abort_clear", io_out, 8'h00);
        tick();
        chk("abort_idle", io_out, 8'h00);
        send_txn(3'b001, 3'b000, 3'b011, 0, 1'b1);
        wait_out(waits, busies);
        chk("t8_wait", 8'(waits), 8'd6);
        drain("t8", 0, 1'b0);

        // Asynchronous reset during OUT beat 1
        send_txn(3'b110, 3'b011, 3'b100, 0, 1'b1);
        wait_out(waits, busies);
        chk("t51_wait", 8'(waits), 8'd6);
        e = sb.pop_front();
        chk("t51_b0", io_out, e);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        e = sb.pop_front();
        chk("t51_b1", io_out, e);
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        data     = 3'd7;
        #1;
        chk("async_reset", io_out, 8'h00);
        sb.delete();
        tick();
        tick();
        chk("reset_hold", io_out, 8'h00);
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("reset_release", io_out, 8'h00);

        // First beat after reset is dividend high: 34 / 5 -> Q=6 R=4
        send_txn(3'b100, 3'b010, 3'b101, 1, 1'b1);
        wait_out(waits, busies);
        chk("t34_wait", 8'(waits), 8'd6);
        drain("t34", 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
